// File: rtl/pc_trace_buffer.sv
// Per-cycle {seq, pc, inst} trace capture into a first-word-fall-through FIFO, drained over valid/ready.
// Optional build macro TRACE_DEDUP_EN: skip samples whose pc repeats the last sampled pc.
module pc_trace_buffer #(
   parameter int DEPTH       = 16,
   parameter int ADDR_W      = 4,
   parameter int MAX_RECORDS = 1500
) (
   input  logic              clk_in,
   input  logic              reset,
   input  logic              start,
   input  logic              cap_en,
   input  logic [31:0]       pc,
   input  logic [31:0]       inst,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [15:0]       out_seq,
   output logic [31:0]       out_pc,
   output logic [31:0]       out_inst,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              done
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_DRAIN,
      ST_DONE
   } state_t;

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
   localparam logic [15:0]     LAST_SEQ = 16'(MAX_RECORDS - 1);

   state_t              state_q;
   state_t              state_d;
   logic [ADDR_W-1:0]   wr_ptr_q;
   logic [ADDR_W-1:0]   rd_ptr_q;
   logic [ADDR_W:0]     count_q;
   logic [15:0]         seq_q;
   logic                overflow_q;

   logic [15:0]         mem_seq  [DEPTH];
   logic [31:0]         mem_pc   [DEPTH];
   logic [31:0]         mem_inst [DEPTH];

   logic                dup;
   logic                vld_p0;
   logic                full;
   logic                pop;
   logic                push;
   logic                drop;

`ifdef TRACE_DEDUP_EN
   logic [31:0]         last_pc_q;
   logic                have_last_q;

   // The first sample after start never compares against a stale pc.
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         last_pc_q   <= '0;
         have_last_q <= 1'b0;
      end else if (state_q == ST_IDLE && start) begin
         have_last_q <= 1'b0;
      end else if (vld_p0) begin
         last_pc_q   <= pc;
         have_last_q <= 1'b1;
      end
   end

   assign dup = have_last_q && (pc == last_pc_q);
`else
   assign dup = 1'b0;
`endif

   // ---- capture stage: decide sample, push, drop ----
   assign vld_p0 = (state_q == ST_CAPTURE) && cap_en && !dup;
   assign full   = (count_q == FULL_CNT);
   assign pop    = out_valid && out_ready;
   assign push   = vld_p0 && (!full || pop);
   assign drop   = vld_p0 && !push;

   always_comb begin
      state_d = state_q;
      done    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (vld_p0 && (seq_q == LAST_SEQ)) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (count_q == '0) state_d = ST_DONE;
         end
         ST_DONE: begin
            done = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         seq_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (vld_p0) seq_q <= seq_q + 1'b1;
         if (drop)   overflow_q <= 1'b1;
      end
   end

   // ---- storage stage: record array, no reset needed since reads are masked ----
   always_ff @(posedge clk_in) begin
      if (push) begin
         mem_seq[wr_ptr_q]  <= seq_q;
         mem_pc[wr_ptr_q]   <= pc;
         mem_inst[wr_ptr_q] <= inst;
      end
   end

   // Head outputs are forced to zero when empty so reset leaves every output at 0.
   assign out_valid = (count_q != '0);
   assign out_seq   = out_valid ? mem_seq[rd_ptr_q]  : '0;
   assign out_pc    = out_valid ? mem_pc[rd_ptr_q]   : '0;
   assign out_inst  = out_valid ? mem_inst[rd_ptr_q] : '0;
   assign count     = count_q;
   assign overflow  = overflow_q;

endmodule
